// File: rtl/config_frame_loader_if.sv
// Bitstream write channel for config_frame_loader: 32-bit words over valid/ready.
interface config_frame_loader_if #(
  parameter int unsigned FrameBitsPerRow = 32
);
  logic [FrameBitsPerRow-1:0] WriteData;
  logic                       WriteStrobe;
  logic                       WriteReady;

  modport master (output WriteData, output WriteStrobe, input  WriteReady);
  modport slave  (input  WriteData, input  WriteStrobe, output WriteReady);
endinterface

// File: rtl/config_frame_loader.sv
// Assembles one configuration frame from the bitstream and strobes exactly one column/frame line.
// Optional FramesWritten counter enabled by CONFIG_FRAME_COUNT_EN.
module config_frame_loader #(
  parameter int unsigned MaxFramesPerCol = 8,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned NumColumns      = 4,
  parameter int unsigned StrobeCycles    = 2
) (
  input  logic                                   CLK,
  input  logic                                   reset,
  config_frame_loader_if.slave                   wr,
  output logic [NumRows*FrameBitsPerRow-1:0]     FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                   Synced,
  output logic                                   ConfigError
`ifdef CONFIG_FRAME_COUNT_EN
  ,
  output logic [15:0]                            FramesWritten
`endif
);

  localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned StbW    = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam int unsigned StrobeW = NumColumns * MaxFramesPerCol;
  localparam logic [31:0] SYNC    = 32'hFAB0_FAB1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, STROBE} state_t;

  state_t            state, state_d;
  logic              ready_q, ready_d;
  logic [RowW-1:0]   row_cnt;
  logic [StbW-1:0]   strobe_cnt;
  logic [7:0]        col_q, frame_q;
  logic              dropped;
  logic              accept, hdr_drop, last_row, last_strobe;
  logic [31:0]       strobe_idx;

  assign wr.WriteReady = ready_q;
  assign accept        = wr.WriteStrobe && ready_q;
  assign hdr_drop      = (32'(wr.WriteData[23:16]) >= NumColumns) ||
                         (32'(wr.WriteData[7:0])   >= MaxFramesPerCol);
  assign last_row      = (32'(row_cnt) == NumRows - 1);
  assign last_strobe   = (32'(strobe_cnt) == StrobeCycles - 1);
  assign strobe_idx    = 32'(col_q) * MaxFramesPerCol + 32'(frame_q);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (accept && wr.WriteData == SYNC) state_d = HEADER;
      HEADER: if (accept) state_d = wr.WriteData[31] ? DATA : IDLE;
      DATA:   if (accept && last_row) state_d = dropped ? HEADER : STROBE;
      STROBE: if (last_strobe) state_d = HEADER;
      default: state_d = IDLE;
    endcase
    // Ready is registered, so it is derived from the state being entered.
    ready_d = (state_d != STROBE);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b1;
      FrameData   <= '0;
      FrameStrobe <= '0;
      Synced      <= 1'b0;
      ConfigError <= 1'b0;
      row_cnt     <= '0;
      strobe_cnt  <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      dropped     <= 1'b0;
`ifdef CONFIG_FRAME_COUNT_EN
      FramesWritten <= '0;
`endif
    end else begin
      ready_q <= ready_d;
      case (state)
        IDLE: if (accept && wr.WriteData == SYNC) Synced <= 1'b1;
        HEADER: if (accept) begin
          if (!wr.WriteData[31]) begin
            Synced <= 1'b0;
          end else begin
            col_q   <= wr.WriteData[23:16];
            frame_q <= wr.WriteData[7:0];
            dropped <= hdr_drop;
            row_cnt <= '0;
            if (hdr_drop) ConfigError <= 1'b1;
          end
        end
        DATA: if (accept) begin
          FrameData[row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= wr.WriteData;
          row_cnt <= row_cnt + 1'b1;
          if (last_row && !dropped) begin
            FrameStrobe <= StrobeW'(1) << strobe_idx;
            strobe_cnt  <= '0;
          end
        end
        STROBE: begin
          if (last_strobe) FrameStrobe <= '0;
          else             strobe_cnt  <= strobe_cnt + 1'b1;
        end
        default: ;
      endcase
`ifdef CONFIG_FRAME_COUNT_EN
      if (state_d == STROBE && state != STROBE && FramesWritten != 16'hFFFF)
        FramesWritten <= FramesWritten + 16'd1;
`endif
    end
  end

endmodule
